// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard unit: forwarding mux selects and divider FSM states.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Start/done handshake between the hazard unit (master) and the multi-cycle divider (slave).
interface hazard_ctrl_if;

    logic div_start;
    logic div_cancel;
    logic div_busy;
    logic div_timeout_err;
    logic div_done;

    modport master (
        output div_start,
        output div_cancel,
        output div_busy,
        output div_timeout_err,
        input  div_done
    );

    modport slave (
        input  div_start,
        input  div_cancel,
        input  div_busy,
        input  div_timeout_err,
        output div_done
    );

endinterface

// File: rtl/hazard_ctrl_div_handshake.sv
// Divider handshake FSM: issues the start pulse, holds E while busy, flags a sticky timeout.
module hazard_ctrl_div_handshake
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_MAX_CYCLES = 40,
    parameter int unsigned CNT_W          = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_opE,
    input  logic                 flush_exc,
    hazard_ctrl_if.master        div_if,
    output logic                 divstall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_MAX_CYCLES);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] busy_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_err;
    logic             start_raw;
    logic             cancel_raw;
    logic             stall_raw;

    assign cnt_inc = busy_cnt + 1'b1;

    // Counter is held at zero in IDLE, so it is already clear on entry to BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DIV_IDLE;
            busy_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == DIV_IDLE) begin
                busy_cnt <= '0;
            end else if (busy_cnt != CNT_MAX) begin
                busy_cnt <= cnt_inc;
                if (cnt_inc == CNT_MAX) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        start_raw  = 1'b0;
        cancel_raw = 1'b0;
        stall_raw  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (div_opE && !flush_exc) begin
                    start_raw  = 1'b1;
                    stall_raw  = 1'b1;
                    state_next = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                cancel_raw = flush_exc;
                if (div_if.div_done || flush_exc) begin
                    state_next = DIV_IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    // Reset is synchronous, so the registered state may still read BUSY during the
    // first rst cycle; every divider-side output is gated with rst directly.
    always_comb begin
        div_if.div_start       = start_raw  && !rst;
        div_if.div_cancel      = cancel_raw && !rst;
        div_if.div_busy        = (state == DIV_BUSY) && !rst;
        div_if.div_timeout_err = timeout_err && !rst;
        divstall               = stall_raw  && !rst;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage core: operand forwarding selects, stall/flush control, divider hold.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned DIV_MAX_CYCLES = 40,
    parameter int unsigned CNT_W          = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              div_opE,
    input  logic              flush_exc,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushE,
    output logic              flushM,
    hazard_ctrl_if.master     div_if
);

    logic lwstall;
    logic brstall;
    logic divstall;
    logic d_hit_e;
    logic d_hit_m_load;

    // A producer matches a consumer only if it writes a register other than $0.
    function automatic logic reg_hit(input logic              we,
                                     input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

    always_comb begin
        forwardAE = FWD_RF;
        if (reg_hit(regwriteM, writeregM, rsE)) begin
            forwardAE = FWD_M;
        end else if (reg_hit(regwriteW, writeregW, rsE)) begin
            forwardAE = FWD_W;
        end
    end

    always_comb begin
        forwardBE = FWD_RF;
        if (reg_hit(regwriteM, writeregM, rtE)) begin
            forwardBE = FWD_M;
        end else if (reg_hit(regwriteW, writeregW, rtE)) begin
            forwardBE = FWD_W;
        end
    end

    assign forwardAD = reg_hit(regwriteM, writeregM, rsD);
    assign forwardBD = reg_hit(regwriteM, writeregM, rtD);

    // Compare in D needs the operand before E finishes, or before a load in M returns.
    assign d_hit_e      = reg_hit(regwriteE, writeregE, rsD) || reg_hit(regwriteE, writeregE, rtD);
    assign d_hit_m_load = reg_hit(memtoregM, writeregM, rsD) || reg_hit(memtoregM, writeregM, rtD);

    assign lwstall = memtoregE && d_hit_e;
    assign brstall = (branchD || jrD) && (d_hit_e || d_hit_m_load);

    hazard_ctrl_div_handshake #(
        .DIV_MAX_CYCLES (DIV_MAX_CYCLES),
        .CNT_W          (CNT_W)
    ) u_div_handshake (
        .clk       (clk),
        .rst       (rst),
        .div_opE   (div_opE),
        .flush_exc (flush_exc),
        .div_if    (div_if),
        .divstall  (divstall)
    );

    // A pending exception flush wins over every stall source.
    always_comb begin
        stallF = (lwstall || brstall || divstall) && !flush_exc;
        stallD = (lwstall || brstall || divstall) && !flush_exc;
        stallE = divstall && !flush_exc;
        flushE = ((lwstall || brstall) && !divstall) || flush_exc;
        flushM = divstall || flush_exc;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with an expected-result queue.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        logic       sf;
        logic       sd;
        logic       se;
        logic       fle;
        logic       flm;
        logic       start;
        logic       cancel;
        logic       busy;
        logic       err;
    } exp_t;

    typedef struct {
        string tag;
        exp_t  e;
    } sb_t;

    logic       clk;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, jrD, div_opE, flush_exc;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, stallF, stallD, stallE, flushE, flushM;

    hazard_ctrl_if dif ();

    hazard_ctrl #(
        .REG_AW         (5),
        .DIV_MAX_CYCLES (40),
        .CNT_W          (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rsD       (rsD),
        .rtD       (rtD),
        .rsE       (rsE),
        .rtE       (rtE),
        .writeregE (writeregE),
        .writeregM (writeregM),
        .writeregW (writeregW),
        .regwriteE (regwriteE),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .memtoregE (memtoregE),
        .memtoregM (memtoregM),
        .branchD   (branchD),
        .jrD       (jrD),
        .div_opE   (div_opE),
        .flush_exc (flush_exc),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .flushE    (flushE),
        .flushM    (flushM),
        .div_if    (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    exp_t        e;
    sb_t         q[$];

    task automatic chk(input string tag, input string fld, input logic [1:0] obs, input logic [1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0b expected=%0b", tag, fld, obs, exp_v);
        end
    endtask

    // Expected outputs are queued with the stimulus and checked at the following negedge.
    task automatic apply(input string tag);
        sb_t s;
        sb_t got;
        s.tag = tag;
        s.e   = e;
        q.push_back(s);
        @(negedge clk);
        got = q.pop_front();
        chk(got.tag, "forwardAE", forwardAE, got.e.fae);
        chk(got.tag, "forwardBE", forwardBE, got.e.fbe);
        chk(got.tag, "forwardAD", {1'b0, forwardAD}, {1'b0, got.e.fad});
        chk(got.tag, "forwardBD", {1'b0, forwardBD}, {1'b0, got.e.fbd});
        chk(got.tag, "stallF", {1'b0, stallF}, {1'b0, got.e.sf});
        chk(got.tag, "stallD", {1'b0, stallD}, {1'b0, got.e.sd});
        chk(got.tag, "stallE", {1'b0, stallE}, {1'b0, got.e.se});
        chk(got.tag, "flushE", {1'b0, flushE}, {1'b0, got.e.fle});
        chk(got.tag, "flushM", {1'b0, flushM}, {1'b0, got.e.flm});
        chk(got.tag, "div_start", {1'b0, dif.div_start}, {1'b0, got.e.start});
        chk(got.tag, "div_cancel", {1'b0, dif.div_cancel}, {1'b0, got.e.cancel});
        chk(got.tag, "div_busy", {1'b0, dif.div_busy}, {1'b0, got.e.busy});
        chk(got.tag, "div_timeout_err", {1'b0, dif.div_timeout_err}, {1'b0, got.e.err});
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        branchD = 1'b0; jrD = 1'b0; div_opE = 1'b0; flush_exc = 1'b0;
        dif.div_done = 1'b0;
    endtask

    // Busy-cycle expectation: stalls held, M bubbled.
    task automatic busy_exp(input logic err_v);
        e = '0; e.busy = 1'b1; e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.flm = 1'b1; e.err = err_v;
    endtask

    task automatic start_exp(input logic err_v);
        e = '0; e.start = 1'b1; e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.flm = 1'b1; e.err = err_v;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clr_in();
        rst = 1'b1;

        e = '0; apply("reset_idle");
        div_opE = 1'b1; regwriteM = 1'b1; writeregM = 5'd5; rsE = 5'd5;
        e = '0; e.fae = 2'b10; apply("reset_gates_div");

        rst = 1'b0; clr_in();
        regwriteM = 1'b1; regwriteW = 1'b1; writeregM = 5'd5; writeregW = 5'd5;
        rsE = 5'd5; rtE = 5'd5; rsD = 5'd5;
        e = '0; e.fae = 2'b10; e.fbe = 2'b10; e.fad = 1'b1; apply("fwd_m_prio");
        regwriteM = 1'b0;
        e = '0; e.fae = 2'b01; e.fbe = 2'b01; apply("fwd_w");
        regwriteM = 1'b1; writeregM = '0; writeregW = '0; rsE = '0; rtE = '0; rsD = '0;
        e = '0; apply("fwd_r0");
        rsE = 5'd7; rtE = 5'd9; writeregM = 5'd9; writeregW = 5'd7; rtD = 5'd9;
        e = '0; e.fae = 2'b01; e.fbe = 2'b10; e.fbd = 1'b1; apply("fwd_mixed");

        clr_in();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rtD = 5'd8;
        e = '0; e.sf = 1'b1; e.sd = 1'b1; e.fle = 1'b1; apply("lw_stall");
        memtoregE = 1'b0; regwriteE = 1'b0; writeregE = '0;
        memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd8;
        e = '0; e.fbd = 1'b1; apply("lw_after");
        clr_in();
        memtoregE = 1'b1; regwriteE = 1'b1;
        e = '0; apply("lw_r0");
        writeregE = 5'd8; rtD = 5'd8; flush_exc = 1'b1;
        e = '0; e.fle = 1'b1; e.flm = 1'b1; apply("lw_flush_override");

        clr_in();
        branchD = 1'b1; rsD = 5'd3; regwriteE = 1'b1; writeregE = 5'd3;
        e = '0; e.sf = 1'b1; e.sd = 1'b1; e.fle = 1'b1; apply("br_stall");
        regwriteE = 1'b0; writeregE = '0; regwriteM = 1'b1; writeregM = 5'd3;
        e = '0; e.fad = 1'b1; apply("br_fwd");
        clr_in();
        jrD = 1'b1; rsD = 5'd4; memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd4;
        e = '0; e.sf = 1'b1; e.sd = 1'b1; e.fle = 1'b1; e.fad = 1'b1; apply("jr_load_m");
        clr_in();
        branchD = 1'b1; rtD = 5'd6; writeregE = 5'd6;
        e = '0; apply("br_no_write");

        clr_in();
        dif.div_done = 1'b1;
        e = '0; apply("done_in_idle");
        dif.div_done = 1'b0;
        e = '0; apply("done_in_idle_after");

        div_opE = 1'b1;
        start_exp(1'b0); apply("div33_start");
        for (int k = 1; k <= 32; k++) begin
            busy_exp(1'b0); apply("div33_busy");
        end
        dif.div_done = 1'b1;
        e = '0; e.busy = 1'b1; apply("div33_done");
        dif.div_done = 1'b0; div_opE = 1'b0;
        e = '0; apply("div33_idle");
        e = '0; apply("div33_no_restart");

        div_opE = 1'b1;
        start_exp(1'b0); apply("flush_start");
        for (int k = 1; k <= 9; k++) begin
            busy_exp(1'b0); apply("flush_busy");
        end
        flush_exc = 1'b1;
        e = '0; e.cancel = 1'b1; e.busy = 1'b1; e.fle = 1'b1; e.flm = 1'b1; apply("flush_cancel");
        flush_exc = 1'b0; div_opE = 1'b0;
        e = '0; apply("flush_idle");

        div_opE = 1'b1; flush_exc = 1'b1;
        e = '0; e.fle = 1'b1; e.flm = 1'b1; apply("flush_in_idle");
        div_opE = 1'b0; flush_exc = 1'b0;
        e = '0; apply("flush_in_idle_after");

        div_opE = 1'b1;
        start_exp(1'b0); apply("dflush_start");
        for (int k = 1; k <= 2; k++) begin
            busy_exp(1'b0); apply("dflush_busy");
        end
        dif.div_done = 1'b1; flush_exc = 1'b1;
        e = '0; e.cancel = 1'b1; e.busy = 1'b1; e.fle = 1'b1; e.flm = 1'b1; apply("done_and_flush");
        dif.div_done = 1'b0; flush_exc = 1'b0; div_opE = 1'b0;
        e = '0; apply("done_and_flush_after");

        div_opE = 1'b1;
        start_exp(1'b0); apply("tmo_start");
        for (int k = 1; k <= 45; k++) begin
            busy_exp(k >= 41); apply(k >= 41 ? "tmo_busy_err" : "tmo_busy");
        end
        dif.div_done = 1'b1;
        e = '0; e.busy = 1'b1; e.err = 1'b1; apply("tmo_done");
        dif.div_done = 1'b0; div_opE = 1'b0;
        e = '0; e.err = 1'b1; apply("tmo_sticky");
        div_opE = 1'b1;
        start_exp(1'b1); apply("tmo_restart");
        for (int k = 1; k <= 3; k++) begin
            busy_exp(1'b1); apply("tmo_busy2");
        end
        rst = 1'b1;
        e = '0; apply("rst_mid_busy");
        rst = 1'b0; div_opE = 1'b0;
        e = '0; apply("rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control end of the datapath operand selectors for the 5-stage MIPS core (F/D/E/M/W).
- Generates the forwarding select codes consumed by the 3-input EX operand muxes and the 2-input ID branch-compare muxes.
- Generates the pipeline stall and flush controls.
- Owns the start/done handshake with the multi-cycle divider, and holds E while a division is in flight.

Parameters:
- REG_AW, 5, register address width.
- DIV_MAX_CYCLES, 40, busy cycles allowed before the timeout error is flagged.
- CNT_W, 6, width of the divider busy-cycle counter; must hold DIV_MAX_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rsD, rtD  in  REG_AW  source registers in D.
- rsE, rtE  in  REG_AW  source registers in E.
- writeregE, writeregM, writeregW  in  REG_AW  destination registers in E, M, W.
- regwriteE, regwriteM, regwriteW  in  1  register write enables in E, M, W.
- memtoregE, memtoregM  in  1  load in E, load in M.
- branchD, jrD  in  1  branch or jr in D.
- div_opE  in  1  div/divu in E.
- div_done  in  1  one-cycle pulse from the divider: result valid.
- flush_exc  in  1  exception/eret flush from M.
- forwardAE, forwardBE  out  2  EX operand select: 00 regfile, 01 W result, 10 M ALU result; 11 never driven.
- forwardAD, forwardBD  out  1  D compare select: 1 selects M ALU result.
- stallF, stallD, stallE  out  1  hold the PC, D and E registers.
- flushE, flushM  out  1  insert a bubble into E or M.
- div_start  out  1  one-cycle start pulse to the divider.
- div_cancel  out  1  abort the divider.
- div_busy  out  1  FSM in BUSY.
- div_timeout_err  out  1  sticky; cleared only by rst.

Behaviour:
- Forwarding (combinational, zero latency):
  - forwardAE = 10 if regwriteM && writeregM!=0 && writeregM==rsE.
  - Else forwardAE = 01 if regwriteW && writeregW!=0 && writeregW==rsE.
  - Else forwardAE = 00. M has priority over W.
  - forwardBE is identical with rtE.
  - forwardAD = regwriteM && writeregM!=0 && writeregM==rsD; forwardBD identical with rtD.
  - Register $0 is never forwarded.
- Hazard terms:
  - lwstall = memtoregE && regwriteE && writeregE!=0 && writeregE matches rsD or rtD.
  - brstall = (branchD||jrD) && [(regwriteE && writeregE!=0 && writeregE matches rsD/rtD) || (memtoregM && writeregM!=0 && writeregM matches rsD/rtD)].
- Divider FSM, states IDLE and BUSY:
  - IDLE: if div_opE && !flush_exc, assert div_start for one cycle and go to BUSY.
  - BUSY: if div_done, go to IDLE. If flush_exc, go to IDLE.
  - divstall = (IDLE && div_opE && !flush_exc) || (BUSY && !div_done && !flush_exc).
  - On div_done in BUSY, stalls drop in that same cycle, so the div instruction leaves E and is not restarted.
  - A following div in E restarts from IDLE normally.
- Busy counter:
  - Cleared on entry to BUSY; increments each BUSY cycle and saturates.
  - Reaching DIV_MAX_CYCLES sets div_timeout_err. The FSM keeps waiting.
- Outputs:
  - stallF = stallD = lwstall || brstall || divstall.
  - stallE = divstall.
  - flushE = ((lwstall||brstall) && !divstall) || flush_exc.
  - flushM = divstall || flush_exc.
  - div_busy = (state==BUSY).
  - div_cancel = flush_exc && BUSY.
- flush_exc overrides every stall: stallF/D/E = 0 that cycle.
- Simultaneous div_done and flush_exc: go to IDLE, div_cancel = 1.
- div_done arriving in IDLE: ignored.
- Reset:
  - While rst is high: state IDLE, counter 0, div_timeout_err 0.
  - div_start, div_cancel, div_busy and divstall are forced to 0.
  - Forwarding, lwstall and brstall remain combinational.
  - rst mid-division abandons the division; the divider is reset by the same rst.

Decomposition:
- Shared package holds:
  - Forwarding encodings FWD_RF=00, FWD_W=01, FWD_M=10.
  - FSM state encodings DIV_IDLE and DIV_BUSY.
- Natural sub-module: div_handshake, containing the FSM, the counter, div_start/div_cancel/div_busy/div_timeout_err and divstall. All forwarding and hazard logic stays in the top module.

Test Plan:
- M and W both write $5 and rsE=5 → forwardAE=10. Clear regwriteM → forwardAE=01. Set writeregM=writeregW=0 → forwardAE=00.
- Load into $8 in E with rtD=8 → stallF=stallD=1, flushE=1, stallE=0 for exactly one cycle.
- beq in D with rsD=3 and an ALU write to $3 in E → one-cycle brstall; next cycle forwardAD=1.
- div_opE=1 with div_done after 33 cycles:
  - div_start pulses once;
  - stallE=1 and flushM=1 for 33 cycles, then 0 in the div_done cycle;
  - div_busy falls;
  - no second div_start.
- flush_exc in the 10th BUSY cycle → div_cancel=1, all stalls 0, flushE=flushM=1; next cycle IDLE.
- Hold div_done low for 45 cycles → div_timeout_err rises at busy count 40 and stays 1 until rst. A synchronous rst mid-BUSY → IDLE with all divider outputs 0.
